word_stream_splitter: RTL

- Sequential, parametrised successor to the fixed 32-bit-to-4-byte splitter.
- Accepts one WORD_W-bit word over a valid/ready handshake and emits its lanes one per handshake, LANE_W bits each, on a valid/ready output stream.
- Lane order (MSB-first or LSB-first) and lane count per word (partial words) are configurable.
- Sits between a word-wide producer (e.g. register file or memory read port) and a narrow sink (byte bus, UART TX, display driver).

---
 rtl/splitter_pkg.sv | 28 ++
 rtl/word_stream_splitter_lane_mux.sv | 31 +++
 rtl/word_stream_splitter.sv | 113 +++++++++++
 3 files changed

// File: rtl/splitter_pkg.sv
// Shared types and helpers for the word-to-lane stream splitter.
// Default widths match the classic 32-bit word split into four bytes.
package splitter_pkg;

    localparam int DEF_WORD_W = 32;
    localparam int DEF_LANE_W = 8;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_e;

    // Lane 0 is the top slice when msb_first is set, otherwise the bottom slice.
    function automatic logic [DEF_LANE_W-1:0] lane_sel(input logic [DEF_WORD_W-1:0] word,
                                                       input int idx,
                                                       input bit msb_first);
        logic [DEF_LANE_W-1:0] lane;
        lane = '0;
        for (int i = 0; i < DEF_WORD_W / DEF_LANE_W; i++) begin
            if (idx == i) begin
                lane = msb_first ? word[DEF_WORD_W-1-i*DEF_LANE_W -: DEF_LANE_W]
                                 : word[i*DEF_LANE_W +: DEF_LANE_W];
            end
        end
        return lane;
    endfunction

endpackage

// File: rtl/word_stream_splitter_lane_mux.sv
// Combinational lane selector: picks lane idx_i out of a held word.
// The default-width build reuses the package helper; other widths use the generic loop.
module lane_mux
    import splitter_pkg::*;
#(
    parameter int WORD_W    = DEF_WORD_W,
    parameter int LANE_W    = DEF_LANE_W,
    parameter bit MSB_FIRST = 1'b1,
    localparam int LANES    = WORD_W / LANE_W,
    localparam int IDX_W    = (LANES > 1) ? $clog2(LANES) : 1
) (
    input  logic [WORD_W-1:0] word_i,
    input  logic [IDX_W-1:0]  idx_i,
    output logic [LANE_W-1:0] lane_o
);

    if (WORD_W == DEF_WORD_W && LANE_W == DEF_LANE_W) begin : g_default
        assign lane_o = lane_sel(word_i, int'(idx_i), MSB_FIRST);
    end else begin : g_generic
        always_comb begin
            lane_o = '0;
            for (int i = 0; i < LANES; i++) begin
                if (idx_i == IDX_W'(i)) begin
                    lane_o = MSB_FIRST ? word_i[WORD_W-1-i*LANE_W -: LANE_W]
                                       : word_i[i*LANE_W +: LANE_W];
                end
            end
        end
    end

endmodule

// File: rtl/word_stream_splitter.sv
// Splits each accepted WORD_W-bit word into LANE_W-bit lanes, one per output handshake.
// Back-to-back words stream without a bubble; word_cnt counts fully emitted words.
module word_stream_splitter
    import splitter_pkg::*;
#(
    parameter int WORD_W    = DEF_WORD_W,
    parameter int LANE_W    = DEF_LANE_W,
    parameter bit MSB_FIRST = 1'b1,
    localparam int LANES    = WORD_W / LANE_W,
    localparam int IDX_W    = (LANES > 1) ? $clog2(LANES) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_data,
    input  logic [IDX_W-1:0]  in_cnt_m1,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [LANE_W-1:0] out_data,
    output logic [IDX_W-1:0]  out_idx,
    output logic              out_last,
    output logic [15:0]       word_cnt
);

    if ((WORD_W % LANE_W) != 0) begin : g_bad_width
        $fatal(1, "word_stream_splitter: WORD_W must be a multiple of LANE_W");
    end

    localparam logic [IDX_W-1:0] MAX_IDX = IDX_W'(LANES - 1);

    state_e              state_q, state_d;
    logic [WORD_W-1:0]   hold_q, hold_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [IDX_W-1:0]    last_idx_q, last_idx_d;
    logic [15:0]         word_cnt_q, word_cnt_d;
    logic [LANE_W-1:0]   lane;
    logic [IDX_W-1:0]    cnt_clamped;
    logic                last_fire;

    lane_mux #(
        .WORD_W   (WORD_W),
        .LANE_W   (LANE_W),
        .MSB_FIRST(MSB_FIRST)
    ) u_lane_mux (
        .word_i(hold_q),
        .idx_i (idx_q),
        .lane_o(lane)
    );

    // Widen before comparing so the clamp stays meaningful when LANES is not a power of two.
    assign cnt_clamped = (32'(in_cnt_m1) >= 32'(LANES)) ? MAX_IDX : in_cnt_m1;

    assign out_valid = (state_q == SEND);
    assign out_last  = out_valid && (idx_q == last_idx_q);
    assign out_idx   = idx_q;
    assign out_data  = out_valid ? lane : '0;
    assign word_cnt  = word_cnt_q;
    assign last_fire = out_valid && out_ready && out_last;
    assign in_ready  = !reset && ((state_q == IDLE) || last_fire);

    always_comb begin
        state_d    = state_q;
        hold_d     = hold_q;
        idx_d      = idx_q;
        last_idx_d = last_idx_q;
        word_cnt_d = word_cnt_q;
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    hold_d     = in_data;
                    last_idx_d = cnt_clamped;
                    idx_d      = '0;
                    state_d    = SEND;
                end
            end
            SEND: begin
                if (out_ready) begin
                    if (out_last) begin
                        word_cnt_d = word_cnt_q + 16'd1;
                        idx_d      = '0;
                        if (in_valid) begin
                            hold_d     = in_data;
                            last_idx_d = cnt_clamped;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            hold_q     <= '0;
            idx_q      <= '0;
            last_idx_q <= '0;
            word_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            hold_q     <= hold_d;
            idx_q      <= idx_d;
            last_idx_q <= last_idx_d;
            word_cnt_q <= word_cnt_d;
        end
    end

endmodule
